// File: rtl/demux_router_if.sv
// Ingress handshake and dual FIFO write-side bundle for demux_router.
// The master drives words and back-pressure; the slave is the router.
interface demux_router_if #(
  parameter int BW    = 6,
  parameter int CNT_W = 8
);
  logic [BW-1:0]    data_in;
  logic             valid_in;
  logic             ready_out;
  logic             almost_full_0;
  logic             almost_full_1;
  logic             push_0;
  logic             push_1;
  logic [BW-1:0]    data_out_0;
  logic [BW-1:0]    data_out_1;
  logic [1:0]       state_out;
  logic [CNT_W-1:0] cnt_0;
  logic [CNT_W-1:0] cnt_1;

  modport master (
    output data_in, valid_in,
    output almost_full_0, almost_full_1,
    input  ready_out, push_0, push_1,
    input  data_out_0, data_out_1,
    input  state_out, cnt_0, cnt_1
  );

  modport slave (
    input  data_in, valid_in,
    input  almost_full_0, almost_full_1,
    output ready_out, push_0, push_1,
    output data_out_0, data_out_1,
    output state_out, cnt_0, cnt_1
  );
endinterface

// File: rtl/demux_router.sv
// One-entry hold buffer routing each word to FIFO 0 or 1 by its MSB.
// Sustains one word per cycle; back-pressure only from the target FIFO.
module demux_router #(
  parameter int BW    = 6,
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      reset_L,
  demux_router_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [BW-1:0]    r_hold;
  logic             r_push_0;
  logic             r_push_1;
  logic [BW-1:0]    r_dout_0;
  logic [BW-1:0]    r_dout_1;
  logic [CNT_W-1:0] r_cnt_0;
  logic [CNT_W-1:0] r_cnt_1;

  logic w_full;
  logic w_dest;
  logic w_af;
  logic w_drain;
  logic w_ready;
  logic w_accept;

  // The hold register is full exactly when the FSM is not idle.
  assign w_full   = (r_state != IDLE);
  assign w_dest   = r_hold[BW-1];
  assign w_af     = w_dest ? bus.almost_full_1
                           : bus.almost_full_0;
  assign w_drain  = w_full & ~w_af;
  assign w_ready  = reset_L & (~w_full | w_drain);
  assign w_accept = bus.valid_in & w_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = HOLD;
      end
      HOLD, STALL: begin
        if (w_drain)
          w_next = w_accept ? HOLD : IDLE;
        else
          w_next = STALL;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_hold <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_push_0 <= 1'b0;
      r_push_1 <= 1'b0;
      r_dout_0 <= '0;
      r_dout_1 <= '0;
      r_cnt_0  <= '0;
      r_cnt_1  <= '0;
    end else begin
      r_push_0 <= w_drain & ~w_dest;
      r_push_1 <= w_drain & w_dest;
      if (w_drain & ~w_dest) begin
        r_dout_0 <= r_hold;
        r_cnt_0  <= r_cnt_0 + 1'b1;
      end
      if (w_drain & w_dest) begin
        r_dout_1 <= r_hold;
        r_cnt_1  <= r_cnt_1 + 1'b1;
      end
    end
  end

  assign bus.ready_out  = w_ready;
  assign bus.push_0     = r_push_0;
  assign bus.push_1     = r_push_1;
  assign bus.data_out_0 = r_dout_0;
  assign bus.data_out_1 = r_dout_1;
  assign bus.state_out  = r_state;
  assign bus.cnt_0      = r_cnt_0;
  assign bus.cnt_1      = r_cnt_1;
endmodule

// File: tb/tb_demux_router.sv
// Scoreboard bench for demux_router: per-port expected-word queues
// filled on acceptance and drained as the FIFO pushes appear.
module tb_demux_router;
  localparam int BW    = 6;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  demux_router_if #(.BW(BW), .CNT_W(CNT_W)) bus ();

  demux_router #(.BW(BW), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [BW-1:0]    q0[$];
  logic [BW-1:0]    q1[$];
  logic [CNT_W-1:0] m_cnt0 = '0;
  logic [CNT_W-1:0] m_cnt1 = '0;

  // Acceptance: expected word queued for its destination port.
  always @(posedge clk) begin
    if (reset_L && bus.valid_in && bus.ready_out) begin
      if (bus.data_in[BW-1]) q1.push_back(bus.data_in);
      else                   q0.push_back(bus.data_in);
    end
  end

  // Output side: every push must match the oldest queued word.
  always @(negedge clk) begin
    logic [BW-1:0] e;
    if (!reset_L) begin
      m_cnt0 = '0;
      m_cnt1 = '0;
    end
    checks++;
    if (bus.push_0 && bus.push_1) begin
      failures++;
      $display("FAIL both_push got=11 exp=at most one");
    end
    if (bus.push_0) begin
      m_cnt0 = m_cnt0 + 1'b1;
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL sb_port0 unexpected push data=%0h", bus.data_out_0);
      end else begin
        e = q0.pop_front();
        if (bus.data_out_0 !== e) begin
          failures++;
          $display("FAIL sb_port0 got=%0h exp=%0h", bus.data_out_0, e);
        end
      end
    end
    if (bus.push_1) begin
      m_cnt1 = m_cnt1 + 1'b1;
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL sb_port1 unexpected push data=%0h", bus.data_out_1);
      end else begin
        e = q1.pop_front();
        if (bus.data_out_1 !== e) begin
          failures++;
          $display("FAIL sb_port1 got=%0h exp=%0h", bus.data_out_1, e);
        end
      end
    end
    checks++;
    if (bus.cnt_0 !== m_cnt0 || bus.cnt_1 !== m_cnt1) begin
      failures++;
      $display("FAIL sb_cnt got=%0d/%0d exp=%0d/%0d",
               bus.cnt_0, bus.cnt_1, m_cnt0, m_cnt1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_L = 1'b0;
    bus.valid_in = 1'b0;
    bus.almost_full_0 = 1'b0;
    bus.almost_full_1 = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    #2;
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    bus.data_in = 6'b111111;
    bus.valid_in = 1'b1;
    bus.almost_full_0 = 1'b0;
    bus.almost_full_1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.ready_out !== 1'b0 || bus.state_out !== 2'd0) begin
      failures++;
      $display("FAIL reset_ctl got=%b/%0d exp=0/0", bus.ready_out, bus.state_out);
    end
    checks++;
    if (bus.push_0 !== 1'b0 || bus.push_1 !== 1'b0 ||
        bus.data_out_0 !== '0 || bus.data_out_1 !== '0) begin
      failures++;
      $display("FAIL reset_out got=%b%b %0h %0h exp=00 0 0",
               bus.push_0, bus.push_1, bus.data_out_0, bus.data_out_1);
    end
    checks++;
    if (bus.cnt_0 !== '0 || bus.cnt_1 !== '0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.cnt_0, bus.cnt_1);
    end
    bus.valid_in = 1'b0;
    #1;
    reset_L = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus.data_in = 6'b100101;
    bus.valid_in = 1'b1;
    #1;
    checks++;
    if (bus.ready_out !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got=%b exp=1", bus.ready_out);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    #1;
    checks++;
    if (bus.state_out !== 2'd1 || bus.push_1 !== 1'b0) begin
      failures++;
      $display("FAIL single_hold got=%0d/%b exp=1/0", bus.state_out, bus.push_1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.push_1 !== 1'b1 || bus.push_0 !== 1'b0 ||
        bus.data_out_1 !== 6'b100101 || bus.cnt_1 !== 8'd1) begin
      failures++;
      $display("FAIL single_push got=%b%b %b %0d exp=01 100101 1",
               bus.push_0, bus.push_1, bus.data_out_1, bus.cnt_1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.push_1 !== 1'b0 || bus.state_out !== 2'd0) begin
      failures++;
      $display("FAIL single_idle got=%b/%0d exp=0/0", bus.push_1, bus.state_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] w;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      w = BW'(i + 1);
      w[BW-1] = i[0];
      bus.data_in = w;
      bus.valid_in = (i < 8);
      #1;
      if (i < 8) begin
        checks++;
        if (bus.ready_out !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready i=%0d got=%b exp=1", i, bus.ready_out);
        end
      end
      if (i >= 2) begin
        checks++;
        if (bus.push_1 !== i[0] || bus.push_0 !== !i[0]) begin
          failures++;
          $display("FAIL b2b_alt i=%0d got=%b%b exp=%b%b",
                   i, bus.push_0, bus.push_1, !i[0], i[0]);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.cnt_0 !== 8'd4 || bus.cnt_1 !== 8'd4) begin
      failures++;
      $display("FAIL b2b_cnt got=%0d/%0d exp=4/4", bus.cnt_0, bus.cnt_1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.data_in = 6'b000011;
    bus.valid_in = 1'b1;
    bus.almost_full_0 = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    #1;
    checks++;
    if (bus.state_out !== 2'd1 || bus.ready_out !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold got=%0d/%b exp=1/0", bus.state_out, bus.ready_out);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.state_out !== 2'd2 || bus.ready_out !== 1'b0 ||
          bus.push_0 !== 1'b0) begin
        failures++;
        $display("FAIL stall_wait k=%0d got=%0d/%b/%b exp=2/0/0",
                 k, bus.state_out, bus.ready_out, bus.push_0);
      end
    end
    @(negedge clk);
    bus.almost_full_0 = 1'b0;
    #1;
    checks++;
    if (bus.push_0 !== 1'b0) begin
      failures++;
      $display("FAIL stall_early got=%b exp=0", bus.push_0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.push_0 !== 1'b1 || bus.data_out_0 !== 6'b000011 ||
        bus.cnt_0 !== 8'd1 || bus.state_out !== 2'd0) begin
      failures++;
      $display("FAIL stall_release got=%b %b %0d %0d exp=1 000011 1 0",
               bus.push_0, bus.data_out_0, bus.cnt_0, bus.state_out);
    end
  endtask

  task automatic test_cross_port();
    logic [BW-1:0] w;
    do_reset();
    bus.almost_full_1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      w = BW'($urandom);
      w[BW-1] = 1'b0;
      bus.data_in = w;
      bus.valid_in = (i < 10);
      #1;
      if (i < 10) begin
        checks++;
        if (bus.ready_out !== 1'b1) begin
          failures++;
          $display("FAIL cross_ready i=%0d got=%b exp=1", i, bus.ready_out);
        end
      end
      if (i >= 2) begin
        checks++;
        if (bus.push_0 !== 1'b1 || bus.push_1 !== 1'b0) begin
          failures++;
          $display("FAIL cross_push i=%0d got=%b%b exp=10",
                   i, bus.push_0, bus.push_1);
        end
      end
    end
    bus.almost_full_1 = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 257; i++) begin
      if (i > 0) @(negedge clk);
      bus.data_in = BW'(i & 31);
      bus.valid_in = 1'b1;
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    #1;
    checks++;
    if (bus.cnt_0 !== 8'd0 || bus.push_0 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_256 got=%0d/%b exp=0/1", bus.cnt_0, bus.push_0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.cnt_0 !== 8'd1) begin
      failures++;
      $display("FAIL wrap_257 got=%0d exp=1", bus.cnt_0);
    end
  endtask

  task automatic test_reset_stall();
    do_reset();
    bus.data_in = 6'b000101;
    bus.valid_in = 1'b1;
    bus.almost_full_0 = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.state_out !== 2'd2) begin
      failures++;
      $display("FAIL rst_stall_pre got=%0d exp=2", bus.state_out);
    end
    #1;
    reset_L = 1'b0;
    q0.delete();
    #1;
    checks++;
    if (bus.state_out !== 2'd0 || bus.ready_out !== 1'b0 ||
        bus.push_0 !== 1'b0 || bus.push_1 !== 1'b0 ||
        bus.data_out_0 !== '0 || bus.data_out_1 !== '0 ||
        bus.cnt_0 !== '0 || bus.cnt_1 !== '0) begin
      failures++;
      $display("FAIL rst_stall_out got=st%0d rdy%b p%b%b c%0d/%0d exp=all 0",
               bus.state_out, bus.ready_out, bus.push_0, bus.push_1,
               bus.cnt_0, bus.cnt_1);
    end
    @(negedge clk);
    #2;
    reset_L = 1'b1;
    @(negedge clk);
    bus.almost_full_0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.push_0 !== 1'b0 || bus.state_out !== 2'd0) begin
        failures++;
        $display("FAIL rst_stall_after k=%0d got=%b/%0d exp=0/0",
                 k, bus.push_0, bus.state_out);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.data_in = BW'($urandom);
      bus.valid_in = ($urandom_range(0, 9) < 7);
      bus.almost_full_0 = ($urandom_range(0, 9) < 3);
      bus.almost_full_1 = ($urandom_range(0, 9) < 3);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.almost_full_0 = 1'b0;
    bus.almost_full_1 = 1'b0;
    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++)
      @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL random_drain got=%0d/%0d pending exp=0/0",
               q0.size(), q1.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_cross_port();
    test_wrap();
    test_reset_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 The block SHALL have parameter BW, default 6, giving the data word width; bit BW-1 is the destination select.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the per-port push counters.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset_L  input  1  reset; asynchronous, active-low.
REQ-005 Port data_in  input  BW  incoming word.
REQ-006 Port valid_in  input  1  data_in carries a word.
REQ-007 Port ready_out  output  1  block can take a word this cycle.
REQ-008 Port almost_full_0 / almost_full_1  input  1 each  downstream FIFO 0/1 must not be pushed.
REQ-009 Port push_0 / push_1  output  1 each  registered write strobe to FIFO 0/1.
REQ-010 Port data_out_0 / data_out_1  output  BW each  registered write data to FIFO 0/1.
REQ-011 Port state_out  output  2  current FSM state: IDLE=0, HOLD=1, STALL=2; 3 is unused.
REQ-012 Port cnt_0 / cnt_1  output  CNT_W each  number of words pushed to port 0/1, modulo 2^CNT_W.

Function
REQ-013 A word SHALL be accepted at a rising edge exactly when valid_in=1 and ready_out=1 in the preceding cycle.
REQ-014 An accepted word SHALL be stored in a one-entry hold register together with its destination, dest = data_in[BW-1].
REQ-015 The block SHALL be able to drain the hold register in a given cycle (drain=1) when it is full and almost_full_<dest>=0.
REQ-016 ready_out SHALL be combinational: ready_out = reset_L & (~hold_full | drain).
REQ-017 At an edge where drain=1, the block SHALL set push_<dest><=1 and data_out_<dest><=held word, and SHALL keep the other push at 0.
REQ-018 Latency SHALL be one cycle: a word captured at edge E appears with push asserted after edge E+1, given almost_full_<dest>=0.
REQ-019 push_0/push_1 SHALL deassert at any edge with no drain; data_out_x SHALL hold its last value while push_x=0.
REQ-020 At most one of push_0/push_1 SHALL be high in any cycle.
REQ-021 Drain and accept in the same cycle SHALL be legal; the new word replaces the held word, sustaining one word per cycle.
REQ-022 FSM IDLE: if valid_in=1, go to HOLD; otherwise stay in IDLE.
REQ-023 FSM HOLD: if drain=1 and a new word is accepted, stay in HOLD.
REQ-024 FSM HOLD: if drain=1 and no word is accepted, go to IDLE.
REQ-025 FSM HOLD: if almost_full_<dest>=1, go to STALL, keeping the held word.
REQ-026 FSM STALL: the block SHALL keep ready_out=0 and push_x=0.
REQ-027 FSM STALL: when almost_full_<dest> falls, the block SHALL drain in that cycle; it goes to HOLD if a new word is accepted in the same cycle, otherwise to IDLE.
REQ-028 almost_full of the non-destination port SHALL have no effect on the block.
REQ-029 cnt_x SHALL increment by 1 at each edge where push_x is set, wrapping from 2^CNT_W-1 to 0.
REQ-030 A held word SHALL never be lost or duplicated.
REQ-031 Words SHALL leave in acceptance order, per port and overall.

Reset
REQ-032 While reset_L=0, the block SHALL immediately force state to IDLE, clear the hold register and drive ready_out=0.
REQ-033 While reset_L=0, the block SHALL drive push_0=push_1=0, data_out_0=data_out_1=0 and cnt_0=cnt_1=0.
REQ-034 Reset asserted mid-operation SHALL discard any held word.
REQ-035 After reset_L rises, the first acceptance SHALL be possible at the first rising edge.

Verification
REQ-036 Single word: after reset, data_in=6'b100101 and valid_in=1 for 1 cycle, both almost_full=0 -> push_1=1 with data_out_1=6'b100101 one cycle after capture; push_0 stays 0; cnt_1=1.
REQ-037 Back-to-back: 8 words alternating MSB 0/1, valid_in held high -> ready_out stays 1, pushes alternate 0/1 every cycle, cnt_0=4, cnt_1=4.
REQ-038 Stall: word 6'b000011 held, almost_full_0=1 for 5 cycles -> state_out=2, ready_out=0, no push; one cycle after almost_full_0 falls, push_0=1 with data 6'b000011, cnt_0=1.
REQ-039 Cross-port independence: almost_full_1=1 constantly, stream of MSB=0 words -> full throughput to port 0, push_1 never asserted.
REQ-040 Wrap: 256 words to port 0 -> cnt_0 returns to 0; the 257th push gives cnt_0=1.
REQ-041 Reset mid-stall: reset_L=0 during STALL -> all outputs 0 and state_out=0; after release, no push of the discarded word ever occurs.
